// File: rtl/sprite_palette_bank.sv
// Banked, runtime-writable sprite palette with a fixed two-cycle lookup pipeline,
// colour-key flagging and a frame-timed hit-flash overlay.
module sprite_palette_bank #(
    parameter int IDX_W        = 4,
    parameter int CH_W         = 4,
    parameter int BANK_W       = 2,
    parameter int TRANSP_IDX   = 0,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                pix_valid,
    input  logic [BANK_W-1:0]   pix_bank,
    input  logic [IDX_W-1:0]    pix_idx,
    input  logic                wr_en,
    input  logic [BANK_W-1:0]   wr_bank,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [3*CH_W-1:0]   wr_rgb,
    input  logic                frame_tick,
    input  logic                flash_start,
    output logic                out_valid,
    output logic [CH_W-1:0]     out_red,
    output logic [CH_W-1:0]     out_green,
    output logic [CH_W-1:0]     out_blue,
    output logic                out_transp,
    output logic                flash_active
);

    localparam int NUM_BANKS = 2 ** BANK_W;
    localparam int DEPTH     = 2 ** IDX_W;
    localparam int RGB_W     = 3 * CH_W;

    typedef logic [RGB_W-1:0] rgb_t;

    // Palette storage, held in flops so every entry clears on reset
    rgb_t palette_reg [NUM_BANKS][DEPTH];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    palette_reg[b][i] <= '0;
                end
            end
        end else if (wr_en) begin
            palette_reg[wr_bank][wr_idx] <= wr_rgb;
        end
    end

    // Stage 1: capture the request
    logic              s1_valid_reg;
    logic [BANK_W-1:0] s1_bank_reg;
    logic [IDX_W-1:0]  s1_idx_reg;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_reg <= 1'b0;
            s1_bank_reg  <= '0;
            s1_idx_reg   <= '0;
        end else begin
            s1_valid_reg <= pix_valid;
            s1_bank_reg  <= pix_bank;
            s1_idx_reg   <= pix_idx;
        end
    end

    // Flash counter: a load always beats a same-cycle decrement
    logic [7:0] cnt_reg;
    logic [7:0] cnt_next;
    logic       flash_active_reg;

    always_comb begin
        cnt_next = cnt_reg;
        if (flash_start) begin
            cnt_next = 8'(FLASH_FRAMES);
        end else if (frame_tick && (cnt_reg != 8'd0)) begin
            cnt_next = cnt_reg - 8'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_reg          <= 8'd0;
            flash_active_reg <= 1'b0;
        end else begin
            cnt_reg          <= cnt_next;
            flash_active_reg <= (cnt_next != 8'd0);
        end
    end

    // Stage 2: read, write-first bypass, colour key and flash overlay
    rgb_t read_rgb;
    rgb_t sel_rgb;
    rgb_t result_rgb;
    logic bypass_hit;
    logic s1_transp;
    logic flash_on;

    always_comb begin
        read_rgb   = palette_reg[s1_bank_reg][s1_idx_reg];
        bypass_hit = wr_en && (wr_bank == s1_bank_reg) && (wr_idx == s1_idx_reg);
        sel_rgb    = bypass_hit ? wr_rgb : read_rgb;
        s1_transp  = (s1_idx_reg == IDX_W'(TRANSP_IDX));
        flash_on   = (cnt_reg != 8'd0) && cnt_reg[0] && !s1_transp;
        result_rgb = flash_on ? '1 : sel_rgb;
    end

    logic out_valid_reg;
    rgb_t out_rgb_reg;
    logic out_transp_reg;

    // Colour and key flag hold their last value across idle cycles
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid_reg  <= 1'b0;
            out_rgb_reg    <= '0;
            out_transp_reg <= 1'b0;
        end else begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_rgb_reg    <= result_rgb;
                out_transp_reg <= s1_transp;
            end
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_red      = out_rgb_reg[RGB_W-1 -: CH_W];
    assign out_green    = out_rgb_reg[2*CH_W-1 -: CH_W];
    assign out_blue     = out_rgb_reg[CH_W-1:0];
    assign out_transp   = out_transp_reg;
    assign flash_active = flash_active_reg;

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Scoreboard bench for sprite_palette_bank: a palette/flash model predicts each
// lookup result, and a monitor compares it whenever the DUT presents out_valid.
module tb_sprite_palette_bank;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        pix_valid = 1'b0;
    logic [1:0]  pix_bank = '0;
    logic [3:0]  pix_idx = '0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_bank = '0;
    logic [3:0]  wr_idx = '0;
    logic [11:0] wr_rgb = '0;
    logic        frame_tick = 1'b0;
    logic        flash_start = 1'b0;
    logic        out_valid;
    logic [3:0]  out_red;
    logic [3:0]  out_green;
    logic [3:0]  out_blue;
    logic        out_transp;
    logic        flash_active;

    sprite_palette_bank dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .pix_valid(pix_valid), .pix_bank(pix_bank), .pix_idx(pix_idx),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_idx(wr_idx), .wr_rgb(wr_rgb),
        .frame_tick(frame_tick), .flash_start(flash_start),
        .out_valid(out_valid), .out_red(out_red), .out_green(out_green),
        .out_blue(out_blue), .out_transp(out_transp), .flash_active(flash_active)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;
    int out_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: palette contents, flash frames remaining, one request in flight
    typedef struct packed {
        logic [11:0] rgb;
        logic        transp;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] m_pal [4][16];
    int          m_frames;
    logic        m_req_v;
    logic [1:0]  m_req_b;
    logic [3:0]  m_req_i;
    logic [11:0] last_rgb;
    logic        last_transp;

    initial begin
        forever begin
            @(posedge Clk or negedge Reset_n);
            if (!Reset_n) begin
                for (int b = 0; b < 4; b++)
                    for (int i = 0; i < 16; i++)
                        m_pal[b][i] = 12'h000;
                m_frames    = 0;
                m_req_v     = 1'b0;
                m_req_b     = '0;
                m_req_i     = '0;
                last_rgb    = 12'h000;
                last_transp = 1'b0;
                exp_q.delete();
            end else begin
                if (m_req_v) begin
                    exp_t e;
                    logic [11:0] colour;
                    e.transp = (m_req_i == 4'd0);
                    if (wr_en && wr_bank == m_req_b && wr_idx == m_req_i)
                        colour = wr_rgb;
                    else
                        colour = m_pal[m_req_b][m_req_i];
                    // Odd frames-remaining counts flash white
                    if (m_frames % 2 == 1 && !e.transp)
                        colour = 12'hFFF;
                    e.rgb = colour;
                    exp_q.push_back(e);
                end
                if (wr_en) m_pal[wr_bank][wr_idx] = wr_rgb;
                if (flash_start) m_frames = 8;
                else if (frame_tick && m_frames > 0) m_frames = m_frames - 1;
                m_req_v = pix_valid;
                m_req_b = pix_bank;
                m_req_i = pix_idx;
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge Clk);
            if (Reset_n) begin
                chk("flash_active", 32'(flash_active), 32'(m_frames != 0));
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        out_count++;
                        chk("out_rgb", {20'd0, out_red, out_green, out_blue}, {20'd0, e.rgb});
                        chk("out_transp", 32'(out_transp), 32'(e.transp));
                        $display("out #%0d rgb=%h%h%h transp=%0d expected rgb=%h transp=%0d",
                                 out_count, out_red, out_green, out_blue, out_transp, e.rgb, e.transp);
                        last_rgb    = e.rgb;
                        last_transp = e.transp;
                    end
                end else begin
                    chk("hold_rgb", {20'd0, out_red, out_green, out_blue}, {20'd0, last_rgb});
                    chk("hold_transp", 32'(out_transp), 32'(last_transp));
                end
            end
        end
    end

    task automatic drive(input logic pv, input logic [1:0] pb, input logic [3:0] pi,
                         input logic we, input logic [1:0] wb, input logic [3:0] wi,
                         input logic [11:0] wrgb, input logic ft, input logic fs);
        @(negedge Clk);
        pix_valid = pv; pix_bank = pb; pix_idx = pi;
        wr_en = we; wr_bank = wb; wr_idx = wi; wr_rgb = wrgb;
        frame_tick = ft; flash_start = fs;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 12'h000, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_rgb"}, {20'd0, out_red, out_green, out_blue}, 32'd0);
        chk({tag, "_out_transp"}, 32'(out_transp), 32'd0);
        chk({tag, "_flash_active"}, 32'(flash_active), 32'd0);
        $display("reset check %s done", tag);
    endtask

    logic [1:0] prev_b;
    logic [3:0] prev_i;

    task automatic random_traffic(input int n);
        for (int k = 0; k < n; k++) begin
            logic       pv, we, ft, fs;
            logic [1:0] pb, wb;
            logic [3:0] pi, wi;
            pv = ($urandom_range(0, 3) != 0);
            pb = 2'($urandom_range(0, 3));
            pi = 4'($urandom_range(0, 15));
            we = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1) begin
                wb = prev_b; wi = prev_i;
            end else begin
                wb = 2'($urandom_range(0, 3)); wi = 4'($urandom_range(0, 15));
            end
            ft = ($urandom_range(0, 7) == 0);
            fs = ($urandom_range(0, 39) == 0);
            drive(pv, pb, pi, we, wb, wi, 12'($urandom_range(0, 4095)), ft, fs);
            prev_b = pb; prev_i = pi;
        end
    endtask

    initial begin
        prev_b = '0; prev_i = '0;
        // Power-on reset
        repeat (3) @(negedge Clk);
        check_reset_outputs("por");
        @(negedge Clk);
        Reset_n = 1'b1;
        idle(2);

        // Single entry write and lookup; another bank stays zero
        drive(0, 0, 0, 1, 2'd1, 4'd3, 12'h9A8, 0, 0);
        drive(1, 2'd1, 4'd3, 0, 0, 0, 12'h000, 0, 0);
        drive(1, 2'd0, 4'd3, 0, 0, 0, 12'h000, 0, 0);
        idle(3);

        // Load bank 0 then stream all 16 indices back to back
        for (int i = 0; i < 16; i++)
            drive(0, 0, 0, 1, 2'd0, 4'(i), 12'($urandom_range(0, 4095)), 0, 0);
        for (int i = 0; i < 16; i++)
            drive(1, 2'd0, 4'(i), 0, 0, 0, 12'h000, 0, 0);
        idle(3);

        // Write-first bypass
        drive(1, 2'd2, 4'd5, 0, 0, 0, 12'h000, 0, 0);
        drive(0, 0, 0, 1, 2'd2, 4'd5, 12'h123, 0, 0);
        idle(3);

        // Flash sequence with mixed opaque and transparent lookups
        drive(0, 0, 0, 1, 2'd3, 4'd7, 12'h5C3, 0, 1);
        for (int t = 0; t < 10; t++) begin
            drive(1, 2'd3, 4'd7, 0, 0, 0, 12'h000, 0, 0);
            drive(1, 2'd3, 4'd0, 0, 0, 0, 12'h000, 1, 0);
            drive(1, 2'd3, 4'd7, 0, 0, 0, 12'h000, 0, 0);
        end
        idle(2);
        chk("flash_expired", 32'(flash_active), 32'd0);

        // Reload coinciding with a tick at 3 frames remaining
        drive(0, 0, 0, 0, 0, 0, 12'h000, 0, 1);
        for (int t = 0; t < 5; t++) drive(0, 0, 0, 0, 0, 0, 12'h000, 1, 0);
        drive(1, 2'd3, 4'd7, 0, 0, 0, 12'h000, 1, 1);
        for (int t = 1; t <= 8; t++) begin
            drive(1, 2'd3, 4'd7, 0, 0, 0, 12'h000, 1, 0);
            @(posedge Clk); #1;
            chk("reload_frames", 32'(flash_active), 32'(t < 8));
        end
        idle(3);

        // Random traffic with an asynchronous reset in the middle
        random_traffic(300);
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1 check_reset_outputs("mid");
        pix_valid = 0; wr_en = 0; frame_tick = 0; flash_start = 0;
        @(negedge Clk);
        Reset_n = 1'b1;
        random_traffic(300);
        idle(4);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("outputs_seen", 32'(out_count > 300), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
